// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the Sync_fifo burst read master.
// Default widths are kept here so FIFO instantiations and the reader stay in step.
package fifo_rd_pkg;

  localparam int unsigned StateW       = 2;
  localparam int unsigned BufDepth     = 3;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefLenW      = 8;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_outbuf.sv
// Small FIFO-ordered valid/ready output buffer; the head entry drives the stream.
// The read master guarantees it never pushes into a full buffer.
module fifo_rd_outbuf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = BufDepth
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_push_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_head,
  output logic                          o_valid,
  output logic [$clog2(DEPTH+1)-1:0]    o_occ
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [OccW-1:0]       r_occ;
  logic                  w_do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop = i_pop && (r_occ != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_occ <= r_occ + OccW'(i_push) - OccW'(w_do_pop);
    end
  end

  // A push into a full buffer without a simultaneous pop would lose data.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push && !w_do_pop) begin
      assert (r_occ < OccW'(DEPTH));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for a Sync_fifo: pops a commanded number of words and
// streams them out on valid/ready with full backpressure.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned BUF_DEPTH  = BufDepth
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [LEN_W-1:0]      i_cmd_len,
  output logic                  o_cmd_ready,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_cs,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

  rd_state_e        r_state;
  logic [LEN_W-1:0] r_rd_left;
  logic [LEN_W-1:0] r_out_left;
  logic             r_inflight;
  logic             r_done;

  logic [OccW-1:0]  w_occ;
  logic [OccW:0]    w_pending;
  logic             w_room;
  logic             w_rd_en;
  logic             w_buf_valid;
  logic             w_pop;

  // Buffer slots already claimed: resident words plus the one returning from the FIFO.
  assign w_pending = {1'b0, w_occ} + {{OccW{1'b0}}, r_inflight};
  assign w_room    = (w_pending < (OccW + 1)'(BUF_DEPTH));
  assign w_rd_en   = (r_state == StRead) && (r_rd_left != '0) && !i_fifo_empty && w_room;
  assign w_pop     = w_buf_valid && i_m_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_rd_left  <= '0;
      r_out_left <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= 1'b0;
      if (w_pop && (r_out_left != '0)) begin
        r_out_left <= r_out_left - 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_rd_left  <= i_cmd_len;
            r_out_left <= i_cmd_len;
            if (i_cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= StRead;
            end
          end
        end
        StRead: begin
          if (w_rd_en) begin
            r_rd_left <= r_rd_left - 1'b1;
            if (r_rd_left == LEN_W'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_pop && (r_out_left == LEN_W'(1))) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  fifo_rd_outbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_outbuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_inflight),
    .i_push_data (i_fifo_data),
    .i_pop       (w_pop),
    .o_head      (o_m_data),
    .o_valid     (w_buf_valid),
    .o_occ       (w_occ)
  );

  assign o_m_valid    = w_buf_valid;
  assign o_fifo_rd_en = w_rd_en;
  assign o_fifo_cs    = w_rd_en;
  assign o_cmd_ready  = (r_state == StIdle);
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader against a behavioural Sync_fifo model.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_len;
  logic        cmd_ready;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        fifo_cs;
  logic        fifo_rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int cs_cnt = 0;
  int underflow = 0;
  int cs_mis = 0;
  int rd0;
  int cs0;

  logic [31:0] beats[$];
  bit          done_seen;

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .i_cmd_len    (cmd_len),
    .o_cmd_ready  (cmd_ready),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_cs    (fifo_cs),
    .o_fifo_rd_en (fifo_rd_en),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_done       (done),
    .o_busy       (busy)
  );

  // Behavioural Sync_fifo: registered data_out, one cycle after a sampled read.
  logic [31:0] fmem [16];
  logic [3:0]  fw = '0;
  logic [3:0]  fr = '0;
  int          fcount = 0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;

  assign fifo_empty = (fcount == 0);

  always @(posedge clk) begin
    if (wr_en) begin
      fmem[fw] <= wr_data;
      fw <= fw + 4'd1;
    end
    if (fifo_cs && fifo_rd_en && fcount != 0) begin
      fifo_data <= fmem[fr];
      fr <= fr + 4'd1;
    end
    fcount <= fcount + (wr_en ? 1 : 0) - ((fifo_cs && fifo_rd_en && fcount != 0) ? 1 : 0);
  end

  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (fifo_cs) cs_cnt++;
    if (fifo_rd_en && fifo_empty) underflow++;
    if (fifo_cs !== fifo_rd_en) cs_mis++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  // Gather accepted beats until done pulses or the cycle budget runs out.
  task automatic collect(input int limit);
    beats.delete();
    done_seen = 1'b0;
    for (int c = 0; c < limit && !done_seen; c++) begin
      if (m_valid && m_ready) beats.push_back(m_data);
      tick();
      if (done) done_seen = 1'b1;
    end
  endtask

  function automatic logic [31:0] beat(input int i);
    return (beats.size() > i) ? beats[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates a pending command
    rst = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd5; m_ready = 1'b0;
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    tick();
    check("idle_busy", busy, 0);

    // Basic burst 1,10,100
    push_word(32'd1); push_word(32'd10); push_word(32'd100);
    rd0 = rd_cnt;
    m_ready = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    check("b_rd_en0", fifo_rd_en, 1);
    check("b_cs0", fifo_cs, 1);
    check("b_valid0", m_valid, 0);
    check("b_busy", busy, 1);
    check("b_cmd_ready", cmd_ready, 0);
    tick();
    check("b_rd_en1", fifo_rd_en, 1);
    check("b_valid1", m_valid, 0);
    tick();
    check("b_valid2", m_valid, 1);
    check("b_data0", m_data, 1);
    check("b_rd_en2", fifo_rd_en, 1);
    tick();
    check("b_data1", m_data, 10);
    check("b_rd_en3", fifo_rd_en, 0);
    tick();
    check("b_data2", m_data, 100);
    check("b_done_early", done, 0);
    tick();
    check("b_valid_end", m_valid, 0);
    check("b_done", done, 1);
    check("b_busy_end", busy, 0);
    tick();
    check("b_done_once", done, 0);
    check("b_reads", rd_cnt - rd0, 3);
    check("b_fifo_empty", fifo_empty, 1);

    // Backpressure: only three reads outstanding while stalled
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'd1 << i);
    rd0 = rd_cnt;
    cmd_valid = 1'b1; cmd_len = 8'd8;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("bp_reads", rd_cnt - rd0, 3);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_valid_hold", m_valid, 1);
    check("bp_data_hold", m_data, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, 32'd1 << i);
      tick();
    end
    check("bp_done", done, 1);
    check("bp_busy", busy, 0);
    check("bp_fifo_empty", fifo_empty, 1);
    tick();

    // Empty stall: 2 of 4 words available up front
    push_word(32'd5); push_word(32'd6);
    rd0 = rd_cnt;
    cmd_valid = 1'b1; cmd_len = 8'd4;
    tick();
    cmd_valid = 1'b0;
    check("es_rd_en0", fifo_rd_en, 1);
    tick();
    check("es_rd_en1", fifo_rd_en, 1);
    tick();
    check("es_rd_en_empty", fifo_rd_en, 0);
    check("es_data0", m_data, 5);
    tick();
    check("es_data1", m_data, 6);
    tick();
    check("es_valid_gap", m_valid, 0);
    repeat (3) tick();
    check("es_rd_en_stall", fifo_rd_en, 0);
    check("es_cs_stall", fifo_cs, 0);
    check("es_busy_stall", busy, 1);
    check("es_done_stall", done, 0);
    check("es_reads_stall", rd_cnt - rd0, 2);
    push_word(32'd7); push_word(32'd8);
    collect(20);
    check("es_beats", beats.size(), 2);
    check("es_data2", beat(0), 7);
    check("es_data3", beat(1), 8);
    check("es_done", done_seen, 1);
    tick();

    // Zero-length command
    rd0 = rd_cnt; cs0 = cs_cnt;
    cmd_valid = 1'b1; cmd_len = 8'd0;
    tick();
    cmd_valid = 1'b0;
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_cmd_ready", cmd_ready, 1);
    tick();
    check("z_done_once", done, 0);
    check("z_busy_after", busy, 0);
    check("z_reads", rd_cnt - rd0, 0);
    check("z_cs", cs_cnt - cs0, 0);

    // Reset mid-burst: words 24..26 are popped but discarded
    for (int i = 0; i < 8; i++) push_word(32'd20 + 32'(i));
    cmd_valid = 1'b1; cmd_len = 8'd8;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("rm_data0", m_data, 20);
    tick(); tick(); tick();
    check("rm_data3", m_data, 23);
    tick();
    rst = 1'b1;
    tick();
    check("rm_m_valid", m_valid, 0);
    check("rm_m_data", m_data, 0);
    check("rm_done", done, 0);
    check("rm_busy", busy, 0);
    check("rm_rd_en", fifo_rd_en, 0);
    check("rm_cs", fifo_cs, 0);
    check("rm_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    push_word(32'd30); push_word(32'd31); push_word(32'd32);
    cmd_valid = 1'b1; cmd_len = 8'd4;
    tick();
    cmd_valid = 1'b0;
    collect(30);
    check("rm_beats", beats.size(), 4);
    check("rm_new0", beat(0), 27);
    check("rm_new1", beat(1), 30);
    check("rm_new2", beat(2), 31);
    check("rm_new3", beat(3), 32);
    check("rm_new_done", done_seen, 1);
    tick();

    check("fifo_drained", fifo_empty, 1);
    check("no_underflow", underflow, 0);
    check("cs_eq_rd_en", cs_mis, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
